// File: rtl/spu_wb_pkg.sv
// Shared widths, the buffered write-back request payload, and the wrap-aware
// issue-tag age comparison used by the register-file write-back arbiter.
package spu_wb_pkg;

   localparam int unsigned DATA_W = 128;
   localparam int unsigned ADDR_W = 7;
   localparam int unsigned TAG_W  = 4;

   typedef struct packed {
      logic [ADDR_W-1:0] rt;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
   } wb_req_t;

   // True when tag a was issued before tag b, modulo 2^TAG_W (15 is older than 0).
   function automatic logic tag_older(input logic [TAG_W-1:0] a,
                                      input logic [TAG_W-1:0] b);
      logic [TAG_W-1:0] diff;
      diff = TAG_W'(b - a);
      return (diff != '0) && !diff[TAG_W-1];
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small per-pipe result buffer with a registered occupancy count.
// Ports:
//   clk, reset      clock, async active-low reset (clears entries and pointers)
//   flush           synchronous discard of all entries; same-cycle push/pop ignored
//   push, pushReq   offer an entry; accepted only when ready_c is high
//   pop             retire the head entry (ignored when empty)
//   ready_c         count < DEPTH, from the registered count only
//   headValid_c     buffer holds at least one entry
//   head_c          oldest buffered entry
module wb_fifo
   import spu_wb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    flush,
   input  logic    push,
   input  wb_req_t pushReq,
   input  logic    pop,
   output logic    ready_c,
   output logic    headValid_c,
   output wb_req_t head_c
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CNT_W-1:0] count;
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   wb_req_t          mem [DEPTH];
   logic             pushOk;
   logic             popOk;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + PTR_W'(1));
   endfunction

   // A full buffer never accepts, even if it pops in the same cycle.
   always_comb begin
      ready_c     = (count < CNT_W'(DEPTH));
      headValid_c = (count != '0);
      head_c      = mem[rdPtr];
      pushOk      = push && ready_c;
      popOk       = pop && headValid_c;
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         wrPtr <= '0;
         rdPtr <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         count <= '0;
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (pushOk) begin
            mem[wrPtr] <= pushReq;
            wrPtr      <= nextPtr(wrPtr);
         end
         if (popOk) begin
            rdPtr <= nextPtr(rdPtr);
         end
         case ({pushOk, popOk})
            2'b10:   count <= CNT_W'(count + CNT_W'(1));
            2'b01:   count <= CNT_W'(count - CNT_W'(1));
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Shares the single register-file write port between the even and odd pipes.
// Each pipe fills a private buffer; each cycle the older buffered head (by
// issue tag, even wins ties) is retired into the registered wb outputs.
// Ports:
//   clk, reset                   clock, async active-low reset
//   flush                        discard all buffered entries, cancel this cycle's write
//   ev_* / od_*                  valid/ready result streams from the even/odd pipes
//   wb_en, wb_rt, wb_data        registered register-file write port
//   idle                         both buffers empty and no write in flight
// Width parameters must match the spu_wb_pkg constants used by the payload struct.
module rf_writeback_arbiter
   import spu_wb_pkg::*;
#(
   parameter int unsigned DATA_W = spu_wb_pkg::DATA_W,
   parameter int unsigned ADDR_W = spu_wb_pkg::ADDR_W,
   parameter int unsigned TAG_W  = spu_wb_pkg::TAG_W,
   parameter int unsigned DEPTH  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              ev_valid,
   output logic              ev_ready,
   input  logic [ADDR_W-1:0] ev_rt,
   input  logic [TAG_W-1:0]  ev_tag,
   input  logic [DATA_W-1:0] ev_data,
   input  logic              od_valid,
   output logic              od_ready,
   input  logic [ADDR_W-1:0] od_rt,
   input  logic [TAG_W-1:0]  od_tag,
   input  logic [DATA_W-1:0] od_data,
   output logic              wb_en,
   output logic [ADDR_W-1:0] wb_rt,
   output logic [DATA_W-1:0] wb_data,
   output logic              idle
);

   wb_req_t evReq;
   wb_req_t odReq;
   wb_req_t evHead_c;
   wb_req_t odHead_c;
   wb_req_t selHead_c;
   logic    evHeadValid_c;
   logic    odHeadValid_c;
   logic    evReady_c;
   logic    odReady_c;
   logic    selOdd_c;
   logic    popEv_c;
   logic    popOd_c;

   always_comb begin
      evReq = '{rt: ev_rt, tag: ev_tag, data: ev_data};
      odReq = '{rt: od_rt, tag: od_tag, data: od_data};
   end

   wb_fifo #(.DEPTH(DEPTH)) u_evFifo (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .push        (ev_valid),
      .pushReq     (evReq),
      .pop         (popEv_c),
      .ready_c     (evReady_c),
      .headValid_c (evHeadValid_c),
      .head_c      (evHead_c)
   );

   wb_fifo #(.DEPTH(DEPTH)) u_odFifo (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .push        (od_valid),
      .pushReq     (odReq),
      .pop         (popOd_c),
      .ready_c     (odReady_c),
      .headValid_c (odHeadValid_c),
      .head_c      (odHead_c)
   );

   // Odd wins only when it is strictly older or the even buffer is empty.
   always_comb begin
      selOdd_c  = odHeadValid_c && (!evHeadValid_c || tag_older(odHead_c.tag, evHead_c.tag));
      selHead_c = selOdd_c ? odHead_c : evHead_c;
      popOd_c   = selOdd_c && !flush;
      popEv_c   = evHeadValid_c && !selOdd_c && !flush;
      ev_ready  = evReady_c;
      od_ready  = odReady_c;
      idle      = !evHeadValid_c && !odHeadValid_c && !wb_en;
   end

   // Write-port registers; address and data hold when nothing retires.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_en   <= 1'b0;
         wb_rt   <= '0;
         wb_data <= '0;
      end else begin
         wb_en <= popEv_c || popOd_c;
         if (popEv_c || popOd_c) begin
            wb_rt   <= selHead_c.rt;
            wb_data <= selHead_c.data;
         end
      end
   end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
module tb_rf_writeback_arbiter;
   import spu_wb_pkg::*;

   logic              clk = 1'b0;
   logic              reset;
   logic              flush;
   logic              ev_valid, od_valid;
   logic              ev_ready, od_ready;
   logic [ADDR_W-1:0] ev_rt, od_rt;
   logic [TAG_W-1:0]  ev_tag, od_tag;
   logic [DATA_W-1:0] ev_data, od_data;
   logic              wb_en;
   logic [ADDR_W-1:0] wb_rt;
   logic [DATA_W-1:0] wb_data;
   logic              idle;

   typedef struct {
      logic [ADDR_W-1:0] rt;
      logic [DATA_W-1:0] data;
   } exp_t;

   exp_t expQ[$];
   exp_t monExp;
   int   testsRun    = 0;
   int   testsFailed = 0;
   int   writeCount  = 0;

   always #5 clk = ~clk;

   rf_writeback_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .ev_rt    (ev_rt),
      .ev_tag   (ev_tag),
      .ev_data  (ev_data),
      .od_valid (od_valid),
      .od_ready (od_ready),
      .od_rt    (od_rt),
      .od_tag   (od_tag),
      .od_data  (od_data),
      .wb_en    (wb_en),
      .wb_rt    (wb_rt),
      .wb_data  (wb_data),
      .idle     (idle)
   );

   task automatic check(input string name, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] req);
      testsRun++;
      if (act !== req) begin
         testsFailed++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic addExp(input logic [ADDR_W-1:0] rt, input logic [DATA_W-1:0] data);
      exp_t e;
      e.rt   = rt;
      e.data = data;
      expQ.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic driveEv(input logic v, input logic [ADDR_W-1:0] rt,
                          input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] d);
      ev_valid = v;
      ev_rt    = rt;
      ev_tag   = tag;
      ev_data  = d;
   endtask

   task automatic driveOd(input logic v, input logic [ADDR_W-1:0] rt,
                          input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] d);
      od_valid = v;
      od_rt    = rt;
      od_tag   = tag;
      od_data  = d;
   endtask

   task automatic quiet();
      driveEv(1'b0, '0, '0, '0);
      driveOd(1'b0, '0, '0, '0);
   endtask

   // Scoreboard monitor: every write must match the next expected entry.
   always @(negedge clk) begin
      if (reset && wb_en) begin
         writeCount++;
         testsRun++;
         if (expQ.size() == 0) begin
            testsFailed++;
            $display("FAIL unexpected_write: actual rt=%0d data=%0h, required no write", wb_rt, wb_data);
         end else begin
            monExp = expQ.pop_front();
            if (wb_rt !== monExp.rt || wb_data !== monExp.data) begin
               testsFailed++;
               $display("FAIL write_order: actual rt=%0d data=%0h required rt=%0d data=%0h",
                        wb_rt, wb_data, monExp.rt, monExp.data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int evIdx, odIdx, accepts, cyc;
      logic evFire, odFire;

      reset = 1'b0;
      flush = 1'b0;
      quiet();
      repeat (2) @(posedge clk);
      #1;
      check("rst_wb_en",    wb_en,    0);
      check("rst_wb_rt",    wb_rt,    0);
      check("rst_wb_data",  wb_data,  0);
      check("rst_ev_ready", ev_ready, 1);
      check("rst_od_ready", od_ready, 1);
      check("rst_idle",     idle,     1);
      reset = 1'b1;
      step();

      // Single write and its latency
      driveEv(1'b1, 7'd5, 4'd1, {16{8'hAA}});
      addExp(7'd5, {16{8'hAA}});
      step();
      quiet();
      @(negedge clk);
      check("t1_wb_en_c1", wb_en, 0);
      check("t1_idle_c1",  idle,  0);
      @(negedge clk);
      check("t1_wb_en_c2", wb_en, 1);
      check("t1_wb_rt_c2", wb_rt, 5);
      @(negedge clk);
      check("t1_wb_en_c3", wb_en, 0);
      check("t1_idle_c3",  idle,  1);
      step();

      // Tag ordering: odd tag 2 beats even tag 3
      driveEv(1'b1, 7'd10, 4'd3, 128'h33);
      driveOd(1'b1, 7'd11, 4'd2, 128'h22);
      addExp(7'd11, 128'h22);
      addExp(7'd10, 128'h33);
      step();
      quiet();
      repeat (4) step();
      check("t2_idle", idle, 1);

      // Tag wrap: even tag 15 is older than odd tag 0
      driveEv(1'b1, 7'd12, 4'd15, 128'hF0F0);
      driveOd(1'b1, 7'd13, 4'd0,  128'h0B0B);
      addExp(7'd12, 128'hF0F0);
      addExp(7'd13, 128'h0B0B);
      step();
      quiet();
      repeat (4) step();

      // Same destination register, tag order decides
      driveEv(1'b1, 7'd9, 4'd4, 128'd1);
      driveOd(1'b1, 7'd9, 4'd5, 128'd2);
      addExp(7'd9, 128'd1);
      addExp(7'd9, 128'd2);
      step();
      quiet();
      repeat (4) step();
      check("t4_idle", idle, 1);

      // Backpressure: even tags 0..3 all older than odd tags 4..7
      writeCount = 0;
      for (int i = 0; i < 4; i++) addExp(ADDR_W'(20 + i), DATA_W'(32'hE000 + i));
      for (int i = 0; i < 4; i++) addExp(ADDR_W'(30 + i), DATA_W'(32'hD000 + i));
      evIdx = 0; odIdx = 0; accepts = 0; cyc = 0;
      while ((evIdx < 4 || odIdx < 4) && cyc < 50) begin
         driveEv(evIdx < 4, ADDR_W'(20 + evIdx), TAG_W'(evIdx),     DATA_W'(32'hE000 + evIdx));
         driveOd(odIdx < 4, ADDR_W'(30 + odIdx), TAG_W'(4 + odIdx), DATA_W'(32'hD000 + odIdx));
         evFire = ev_valid && ev_ready;
         odFire = od_valid && od_ready;
         if (cyc == 2) begin
            check("t5_od_ready_drop", od_ready, 0);
            check("t5_od_accepts_at_stall", DATA_W'(odIdx), 2);
         end
         step();
         if (evFire) begin evIdx++; accepts++; end
         if (odFire) begin odIdx++; accepts++; end
         cyc++;
      end
      check("t5_stream_done", DATA_W'(cyc < 50), 1);
      quiet();
      repeat (6) step();
      check("t5_writes_eq_accepts", DATA_W'(writeCount), DATA_W'(accepts));
      check("t5_writes_total", DATA_W'(writeCount), 8);
      check("t5_idle", idle, 1);

      // Flush with both buffers occupied
      driveEv(1'b1, 7'd40, 4'd0, 128'h40);
      driveOd(1'b1, 7'd41, 4'd1, 128'h41);
      addExp(7'd40, 128'h40);
      step();
      driveEv(1'b1, 7'd42, 4'd2, 128'h42);
      driveOd(1'b1, 7'd43, 4'd3, 128'h43);
      step();
      flush = 1'b1;
      driveEv(1'b1, 7'd44, 4'd4, 128'h44);
      driveOd(1'b0, '0, '0, '0);
      check("t6_od_full_before_flush", od_ready, 0);
      step();
      flush = 1'b0;
      quiet();
      check("t6_wb_en_after_flush", wb_en,    0);
      check("t6_idle_after_flush",  idle,     1);
      check("t6_ev_ready",          ev_ready, 1);
      check("t6_od_ready",          od_ready, 1);
      repeat (4) step();
      check("t6_idle_later", idle, 1);

      // Asynchronous reset mid-stream
      driveEv(1'b1, 7'd50, 4'd5, 128'h50);
      driveOd(1'b1, 7'd51, 4'd6, 128'h51);
      step();
      quiet();
      #1;
      reset = 1'b0;
      #1;
      check("t7_wb_en",    wb_en,    0);
      check("t7_wb_rt",    wb_rt,    0);
      check("t7_wb_data",  wb_data,  0);
      check("t7_idle",     idle,     1);
      step();
      reset = 1'b1;
      repeat (3) step();
      check("t7_ev_ready_after", ev_ready, 1);
      check("t7_od_ready_after", od_ready, 1);
      check("t7_idle_after",     idle,     1);

      check("scoreboard_empty", DATA_W'(expQ.size()), 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
